// File: rtl/axi_id_remap_table.sv
// axi_id_remap_table: remaps wide upstream AXI IDs onto a small table of downstream IDs and restores them on responses
module axi_id_remap_table #(
  parameter int InIdWidth    = 8,
  parameter int OutIdWidth   = 2,
  parameter int TableSize    = 4,
  parameter int MaxTxnsPerId = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slv_req_valid_i,
  output logic                  slv_req_ready_o,
  input  logic [InIdWidth-1:0]  slv_req_id_i,
  output logic                  mst_req_valid_o,
  input  logic                  mst_req_ready_i,
  output logic [OutIdWidth-1:0] mst_req_id_o,
  input  logic                  mst_rsp_valid_i,
  output logic                  mst_rsp_ready_o,
  input  logic [OutIdWidth-1:0] mst_rsp_id_i,
  input  logic                  mst_rsp_last_i,
  output logic                  slv_rsp_valid_o,
  input  logic                  slv_rsp_ready_i,
  output logic [InIdWidth-1:0]  slv_rsp_id_o,
  output logic                  slv_rsp_last_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  unexp_rsp_o
);
  localparam int CntW = $clog2(MaxTxnsPerId + 1);
  logic [TableSize-1:0]  used_q;
  logic [InIdWidth-1:0]  in_id_q [TableSize];
  logic [CntW-1:0]       cnt_q [TableSize];
  logic                  match, match_sat, free, rsp_hit, acc, req_fire, rsp_fire;
  logic [OutIdWidth-1:0] match_idx, free_idx, req_idx;
  logic [InIdWidth-1:0]  rsp_in;
  logic [TableSize-1:0]  inc, dec;
  always_comb begin
    match     = 1'b0;
    match_sat = 1'b0;
    match_idx = '0;
    free      = 1'b0;
    free_idx  = '0;
    rsp_hit   = 1'b0;
    rsp_in    = '0;
    for (int i = TableSize - 1; i >= 0; i--) begin
      if (used_q[i] && in_id_q[i] == slv_req_id_i) begin
        match     = 1'b1;
        match_sat = cnt_q[i] >= CntW'(MaxTxnsPerId);
        match_idx = OutIdWidth'(i);
      end
      if (!used_q[i]) begin
        free     = 1'b1;
        free_idx = OutIdWidth'(i);
      end
      if (used_q[i] && mst_rsp_id_i == OutIdWidth'(i)) begin
        rsp_hit = 1'b1;
        rsp_in  = in_id_q[i];
      end
    end
  end
  assign acc             = match ? !match_sat : free;
  assign req_idx         = match ? match_idx : free_idx;
  assign mst_req_valid_o = slv_req_valid_i & acc;
  assign slv_req_ready_o = mst_req_ready_i & acc;
  assign mst_req_id_o    = req_idx;
  assign req_fire        = slv_req_valid_i & mst_req_ready_i & acc;
  assign slv_rsp_valid_o = mst_rsp_valid_i;
  assign mst_rsp_ready_o = slv_rsp_ready_i;
  assign slv_rsp_id_o    = rsp_in;
  assign slv_rsp_last_o  = mst_rsp_last_i;
  assign rsp_fire        = mst_rsp_valid_i & slv_rsp_ready_i & mst_rsp_last_i & rsp_hit;
  assign unexp_rsp_o     = mst_rsp_valid_i & slv_rsp_ready_i & !rsp_hit;
  assign full_o          = &used_q;
  assign empty_o         = ~|used_q;
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < TableSize; i++) begin
      inc[i] = req_fire && req_idx == OutIdWidth'(i);
      dec[i] = rsp_fire && mst_rsp_id_i == OutIdWidth'(i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      used_q  <= '0;
      in_id_q <= '{default: '0};
      cnt_q   <= '{default: '0};
    end else begin
      for (int i = 0; i < TableSize; i++) begin
        if (inc[i] && !used_q[i]) begin
          used_q[i]  <= 1'b1;
          in_id_q[i] <= slv_req_id_i;
          cnt_q[i]   <= CntW'(1);
        end else if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end else if (dec[i] && !inc[i]) begin
          cnt_q[i] <= cnt_q[i] - CntW'(1);
          if (cnt_q[i] == CntW'(1)) used_q[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_id_remap_table.sv
// tb_axi_id_remap_table: directed and random checks of the ID remap table against a table model
module tb_axi_id_remap_table;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       slv_req_valid_i, slv_req_ready_o;
  logic [7:0] slv_req_id_i;
  logic       mst_req_valid_o, mst_req_ready_i;
  logic [1:0] mst_req_id_o;
  logic       mst_rsp_valid_i, mst_rsp_ready_o;
  logic [1:0] mst_rsp_id_i;
  logic       mst_rsp_last_i, slv_rsp_valid_o, slv_rsp_ready_i;
  logic [7:0] slv_rsp_id_o;
  logic       slv_rsp_last_o, full_o, empty_o, unexp_rsp_o;
  int vecs = 0;
  int errs = 0;
  bit       m_used [4];
  bit [7:0] m_id [4];
  int       m_cnt [4];
  axi_id_remap_table dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_req_valid_i(slv_req_valid_i), .slv_req_ready_o(slv_req_ready_o), .slv_req_id_i(slv_req_id_i),
    .mst_req_valid_o(mst_req_valid_o), .mst_req_ready_i(mst_req_ready_i), .mst_req_id_o(mst_req_id_o),
    .mst_rsp_valid_i(mst_rsp_valid_i), .mst_rsp_ready_o(mst_rsp_ready_o), .mst_rsp_id_i(mst_rsp_id_i),
    .mst_rsp_last_i(mst_rsp_last_i), .slv_rsp_valid_o(slv_rsp_valid_o), .slv_rsp_ready_i(slv_rsp_ready_i),
    .slv_rsp_id_o(slv_rsp_id_o), .slv_rsp_last_o(slv_rsp_last_o),
    .full_o(full_o), .empty_o(empty_o), .unexp_rsp_o(unexp_rsp_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int m_match(input bit [7:0] id);
    for (int e = 0; e < 4; e++) if (m_used[e] && m_id[e] == id) return e;
    return -1;
  endfunction
  function automatic int m_free();
    for (int e = 0; e < 4; e++) if (!m_used[e]) return e;
    return -1;
  endfunction
  function automatic int m_count();
    int n = 0;
    for (int e = 0; e < 4; e++) n += m_used[e];
    return n;
  endfunction
  task automatic do_reset();
    rst_i = 1'b1;
    slv_req_valid_i = 0; slv_req_id_i = 0; mst_req_ready_i = 0;
    mst_rsp_valid_i = 0; mst_rsp_id_i = 0; mst_rsp_last_i = 0; slv_rsp_ready_i = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int e = 0; e < 4; e++) begin m_used[e] = 0; m_id[e] = 0; m_cnt[e] = 0; end
  endtask
  task automatic step(input bit rv, input bit [7:0] rid, input bit mr,
                      input bit pv, input bit [1:0] pid, input bit pl, input bit sr);
    int mi, fi, e;
    bit acc, hit;
    slv_req_valid_i = rv; slv_req_id_i = rid; mst_req_ready_i = mr;
    mst_rsp_valid_i = pv; mst_rsp_id_i = pid; mst_rsp_last_i = pl; slv_rsp_ready_i = sr;
    #3;
    mi  = m_match(rid);
    fi  = m_free();
    acc = (mi >= 0) ? (m_cnt[mi] < 2) : (fi >= 0);
    e   = (mi >= 0) ? mi : fi;
    hit = m_used[pid];
    chk("req_valid", mst_req_valid_o, rv & acc);
    chk("req_ready", slv_req_ready_o, mr & acc);
    if (rv && acc) chk("req_id", mst_req_id_o, e);
    chk("rsp_valid", slv_rsp_valid_o, pv);
    chk("rsp_ready", mst_rsp_ready_o, sr);
    chk("rsp_last", slv_rsp_last_o, pl);
    chk("rsp_id", slv_rsp_id_o, hit ? m_id[pid] : 8'h00);
    chk("unexp", unexp_rsp_o, pv & sr & !hit);
    chk("full", full_o, m_count() == 4);
    chk("empty", empty_o, m_count() == 0);
    if (rv && mr && acc) begin
      if (mi >= 0) m_cnt[mi]++;
      else begin m_used[fi] = 1; m_id[fi] = rid; m_cnt[fi] = 1; end
    end
    if (pv && sr && pl && hit) begin
      m_cnt[pid]--;
      if (m_cnt[pid] == 0) m_used[pid] = 0;
    end
    @(posedge clk_i); #1;
  endtask
  initial begin
    do_reset();
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    step(0, 8'h00, 0, 0, 0, 0, 0);
    step(1, 8'h10, 1, 0, 0, 0, 0);
    chk("first_not_empty", empty_o, 0);
    step(1, 8'h20, 1, 0, 0, 0, 0);
    step(1, 8'h30, 1, 0, 0, 0, 0);
    step(1, 8'h40, 1, 0, 0, 0, 0);
    chk("fill_full", full_o, 1);
    step(1, 8'h50, 1, 0, 0, 0, 0);
    step(1, 8'h10, 1, 0, 0, 0, 0);
    step(1, 8'h10, 1, 0, 0, 0, 0);
    step(0, 8'h00, 0, 1, 2, 1, 1);
    step(0, 8'h00, 0, 1, 0, 1, 1);
    step(0, 8'h00, 0, 1, 1, 1, 1);
    step(0, 8'h00, 0, 1, 3, 1, 1);
    chk("entry0_held", empty_o, 0);
    step(0, 8'h00, 0, 1, 0, 1, 1);
    chk("drained", empty_o, 1);
    step(1, 8'h10, 1, 0, 0, 0, 0);
    step(1, 8'h20, 1, 0, 0, 0, 0);
    step(0, 8'h00, 0, 1, 1, 0, 1);
    step(0, 8'h00, 0, 1, 3, 1, 1);
    step(1, 8'h30, 1, 0, 0, 0, 0);
    step(1, 8'h40, 1, 0, 0, 0, 0);
    step(1, 8'h50, 1, 1, 1, 1, 1);
    step(1, 8'h50, 1, 0, 0, 0, 0);
    step(0, 8'h00, 0, 1, 3, 1, 1);
    do_reset();
    step(0, 8'h00, 0, 0, 0, 0, 0);
    step(1, 8'h70, 1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 1), 8'($urandom_range(1, 6) << 4), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
